ladybird_aclint: RTL and testbench

AXI4-Lite responder implementing the machine-level ACLINT registers (MSIP, MTIMECMP, MTIME) for hart 0. Sits on the core's AXI data bus next to simulation memory. Decodes reads and writes from the core and maintains a free-running 64-bit timer. Drives the machine timer and software interrupt lines back into the core.

---
 rtl/ladybird_aclint_pkg.sv | 47 ++++
 rtl/ladybird_aclint_if.sv | 39 +++
 rtl/ladybird_aclint_timer.sv | 63 ++++++
 rtl/ladybird_aclint.sv | 208 ++++++++++++++++++++
 tb/tb_ladybird_aclint.sv | 249 ++++++++++++++++++++++++
 5 files changed

// File: rtl/ladybird_aclint_pkg.sv
// rtl/ladybird_aclint_pkg.sv - shared types, addresses and helpers for the ACLINT responder
package ladybird_aclint_pkg;

   // Default register addresses for hart 0
   localparam logic [31:0] ACLINT_MSIP_BASE     = 32'h0200_0000;
   localparam logic [31:0] ACLINT_MTIMECMP_BASE = 32'h0200_4000;
   localparam logic [31:0] ACLINT_MTIME_BASE    = 32'h0200_BFF8;

   // Offset of the upper word of the 64-bit registers
   localparam logic [31:0] HI_WORD_OFFSET = 32'h0000_0004;

   // Low address bits ignored by decode (word-aligned map)
   localparam logic [31:0] WORD_MASK = 32'h0000_0003;

   localparam logic [1:0]  AXI_RESP_OKAY   = 2'b00;
   localparam logic [1:0]  AXI_RESP_SLVERR = 2'b10;

   localparam logic [63:0] MTIMECMP_RESET = 64'hFFFF_FFFF_FFFF_FFFF;

   typedef enum logic [1:0] {
      IDLE,
      WCOLLECT,
      BRESP,
      RRESP
   } aclint_state_e;

   typedef enum logic [2:0] {
      REG_NONE,
      REG_MSIP,
      REG_MTIMECMP_LO,
      REG_MTIMECMP_HI,
      REG_MTIME_LO,
      REG_MTIME_HI
   } aclint_reg_e;

   // Merge a bus write into an existing word, byte by byte
   function automatic logic [31:0] apply_wstrb(input logic [31:0] old_word,
                                               input logic [31:0] new_word,
                                               input logic [3:0]  strb);
      logic [31:0] merged;
      for (int i = 0; i < 4; i++) begin
         merged[8*i +: 8] = strb[i] ? new_word[8*i +: 8] : old_word[8*i +: 8];
      end
      return merged;
   endfunction

endpackage

// File: rtl/ladybird_aclint_if.sv
// rtl/ladybird_aclint_if.sv - AXI4-Lite bus bundle with master/slave views
interface ladybird_axi_interface #(
   parameter int AXI_DATA_W = 32,
   parameter int AXI_ADDR_W = 32
);
   localparam int AXI_STRB_W = AXI_DATA_W / 8;

   logic [AXI_ADDR_W-1:0] awaddr;
   logic                  awvalid;
   logic                  awready;

   logic [AXI_DATA_W-1:0] wdata;
   logic [AXI_STRB_W-1:0] wstrb;
   logic                  wvalid;
   logic                  wready;

   logic [1:0]            bresp;
   logic                  bvalid;
   logic                  bready;

   logic [AXI_ADDR_W-1:0] araddr;
   logic                  arvalid;
   logic                  arready;

   logic [AXI_DATA_W-1:0] rdata;
   logic [1:0]            rresp;
   logic                  rvalid;
   logic                  rready;

   modport master (
      output awaddr, awvalid, wdata, wstrb, wvalid, bready, araddr, arvalid, rready,
      input  awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
   );

   modport slave (
      input  awaddr, awvalid, wdata, wstrb, wvalid, bready, araddr, arvalid, rready,
      output awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
   );
endinterface

// File: rtl/ladybird_aclint_timer.sv
// rtl/ladybird_aclint_timer.sv - mtime counter, tick divider and timer compare
module ladybird_aclint_timer
   import ladybird_aclint_pkg::*;
#(
   parameter int unsigned TICK_DIV = 1
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        we_lo,
   input  logic        we_hi,
   input  logic [31:0] wdata,
   input  logic [3:0]  wstrb,
   input  logic [63:0] mtimecmp,
   output logic [63:0] mtime,
   output logic        timer_interrupt
);

   localparam int unsigned      TICK_W    = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
   localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(TICK_DIV - 1);
   localparam logic [TICK_W-1:0] TICK_ONE  = 1;

   logic [TICK_W-1:0] tick_cnt;
   logic              tick_wrap;

   assign tick_wrap = (tick_cnt == TICK_LAST);

   // Prescaler: one mtime increment every TICK_DIV clocks
   always_ff @(posedge clk) begin
      if (rst) begin
         tick_cnt <= '0;
      end else if (tick_wrap) begin
         tick_cnt <= '0;
      end else begin
         tick_cnt <= tick_cnt + TICK_ONE;
      end
   end

   // mtime: a bus write beats the increment, and only the written word moves
   always_ff @(posedge clk) begin
      if (rst) begin
         mtime <= '0;
      end else if (we_lo || we_hi) begin
         if (we_lo) begin
            mtime[31:0] <= apply_wstrb(mtime[31:0], wdata, wstrb);
         end
         if (we_hi) begin
            mtime[63:32] <= apply_wstrb(mtime[63:32], wdata, wstrb);
         end
      end else if (tick_wrap) begin
         mtime <= mtime + 64'd1;
      end
   end

   // MTIP follows the registered mtime/mtimecmp one cycle later
   always_ff @(posedge clk) begin
      if (rst) begin
         timer_interrupt <= 1'b0;
      end else begin
         timer_interrupt <= (mtime >= mtimecmp);
      end
   end

endmodule

// File: rtl/ladybird_aclint.sv
// rtl/ladybird_aclint.sv - AXI4-Lite ACLINT responder (msip, mtimecmp, mtime) for hart 0
module ladybird_aclint
   import ladybird_aclint_pkg::*;
#(
   parameter logic [31:0] MSIP_BASE     = ACLINT_MSIP_BASE,
   parameter logic [31:0] MTIMECMP_BASE = ACLINT_MTIMECMP_BASE,
   parameter logic [31:0] MTIME_BASE    = ACLINT_MTIME_BASE,
   parameter int unsigned TICK_DIV      = 1
) (
   input  logic                  clk,
   input  logic                  rst,
   ladybird_axi_interface.slave  axi,
   output logic                  timer_interrupt,
   output logic                  software_interrupt
);

   aclint_state_e state, state_next;

   logic        aw_held, w_held;
   logic [31:0] aw_addr_q, w_data_q;
   logic [3:0]  w_strb_q;
   logic [1:0]  bresp_q, rresp_q;
   logic [31:0] rdata_q;

   logic        msip;
   logic [63:0] mtimecmp;
   logic [63:0] mtime;

   logic        aw_hs, w_hs, ar_hs, commit;
   logic [31:0] wr_addr, wr_data;
   logic [3:0]  wr_strb;
   aclint_reg_e wr_reg, rd_reg;
   logic [31:0] rd_word;

   // Word-granular address decode; the two low address bits never matter
   function automatic aclint_reg_e decode_addr(input logic [31:0] addr);
      logic [31:0] a;
      a = addr | WORD_MASK;
      if (a == (MSIP_BASE | WORD_MASK))                           return REG_MSIP;
      if (a == (MTIMECMP_BASE | WORD_MASK))                       return REG_MTIMECMP_LO;
      if (a == ((MTIMECMP_BASE + HI_WORD_OFFSET) | WORD_MASK))    return REG_MTIMECMP_HI;
      if (a == (MTIME_BASE | WORD_MASK))                          return REG_MTIME_LO;
      if (a == ((MTIME_BASE + HI_WORD_OFFSET) | WORD_MASK))       return REG_MTIME_HI;
      return REG_NONE;
   endfunction

   // A half-collected write takes its missing half straight off the bus
   assign wr_addr = aw_held ? aw_addr_q : axi.awaddr;
   assign wr_data = w_held  ? w_data_q  : axi.wdata;
   assign wr_strb = w_held  ? w_strb_q  : axi.wstrb;
   assign wr_reg  = decode_addr(wr_addr);
   assign rd_reg  = decode_addr(axi.araddr);

   assign axi.bvalid = (state == BRESP);
   assign axi.rvalid = (state == RRESP);
   assign axi.bresp  = bresp_q;
   assign axi.rresp  = rresp_q;
   assign axi.rdata  = rdata_q;

   // Read mux over the current (pre-increment) register values
   always_comb begin
      rd_word = '0;
      case (rd_reg)
         REG_MSIP:        rd_word = {31'b0, msip};
         REG_MTIMECMP_LO: rd_word = mtimecmp[31:0];
         REG_MTIMECMP_HI: rd_word = mtimecmp[63:32];
         REG_MTIME_LO:    rd_word = mtime[31:0];
         REG_MTIME_HI:    rd_word = mtime[63:32];
         default:         rd_word = '0;
      endcase
   end

   // FSM state register
   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
      end else begin
         state <= state_next;
      end
   end

   // Ready generation, handshakes and next state; writes beat reads in IDLE
   always_comb begin
      axi.awready = 1'b0;
      axi.wready  = 1'b0;
      axi.arready = 1'b0;
      state_next  = state;
      commit      = 1'b0;

      case (state)
         IDLE: begin
            axi.awready = !rst;
            axi.wready  = !rst;
            axi.arready = !rst && !axi.awvalid && !axi.wvalid;
         end
         WCOLLECT: begin
            axi.awready = !aw_held;
            axi.wready  = !w_held;
         end
         default: ;
      endcase

      aw_hs = axi.awvalid && axi.awready;
      w_hs  = axi.wvalid  && axi.wready;
      ar_hs = axi.arvalid && axi.arready;

      case (state)
         IDLE: begin
            if (aw_hs && w_hs) begin
               commit     = 1'b1;
               state_next = BRESP;
            end else if (aw_hs || w_hs) begin
               state_next = WCOLLECT;
            end else if (ar_hs) begin
               state_next = RRESP;
            end
         end
         WCOLLECT: begin
            if (aw_hs || w_hs) begin
               commit     = 1'b1;
               state_next = BRESP;
            end
         end
         BRESP: begin
            if (axi.bready) state_next = IDLE;
         end
         RRESP: begin
            if (axi.rready) state_next = IDLE;
         end
         default: state_next = IDLE;
      endcase
   end

   // Hold whichever write half arrived first until its partner shows up
   always_ff @(posedge clk) begin
      if (rst) begin
         aw_held   <= 1'b0;
         w_held    <= 1'b0;
         aw_addr_q <= '0;
         w_data_q  <= '0;
         w_strb_q  <= '0;
      end else if (commit) begin
         aw_held <= 1'b0;
         w_held  <= 1'b0;
      end else begin
         if (aw_hs) begin
            aw_held   <= 1'b1;
            aw_addr_q <= axi.awaddr;
         end
         if (w_hs) begin
            w_held   <= 1'b1;
            w_data_q <= axi.wdata;
            w_strb_q <= axi.wstrb;
         end
      end
   end

   // msip and mtimecmp registers, written on the commit edge
   always_ff @(posedge clk) begin
      if (rst) begin
         msip     <= 1'b0;
         mtimecmp <= MTIMECMP_RESET;
      end else if (commit) begin
         case (wr_reg)
            REG_MSIP: begin
               if (wr_strb[0]) msip <= wr_data[0];
            end
            REG_MTIMECMP_LO: mtimecmp[31:0]  <= apply_wstrb(mtimecmp[31:0],  wr_data, wr_strb);
            REG_MTIMECMP_HI: mtimecmp[63:32] <= apply_wstrb(mtimecmp[63:32], wr_data, wr_strb);
            default: ;
         endcase
      end
   end

   // Response capture and the registered software interrupt
   always_ff @(posedge clk) begin
      if (rst) begin
         bresp_q            <= AXI_RESP_OKAY;
         rresp_q            <= AXI_RESP_OKAY;
         rdata_q            <= '0;
         software_interrupt <= 1'b0;
      end else begin
         if (commit) begin
            bresp_q <= (wr_reg == REG_NONE) ? AXI_RESP_SLVERR : AXI_RESP_OKAY;
         end
         if (ar_hs) begin
            rdata_q <= rd_word;
            rresp_q <= (rd_reg == REG_NONE) ? AXI_RESP_SLVERR : AXI_RESP_OKAY;
         end
         software_interrupt <= msip;
      end
   end

   ladybird_aclint_timer #(
      .TICK_DIV (TICK_DIV)
   ) u_timer (
      .clk             (clk),
      .rst             (rst),
      .we_lo           (commit && (wr_reg == REG_MTIME_LO)),
      .we_hi           (commit && (wr_reg == REG_MTIME_HI)),
      .wdata           (wr_data),
      .wstrb           (wr_strb),
      .mtimecmp        (mtimecmp),
      .mtime           (mtime),
      .timer_interrupt (timer_interrupt)
   );

endmodule

// File: tb/tb_ladybird_aclint.sv
// tb/tb_ladybird_aclint.sv - directed scoreboard bench for the ACLINT responder
module tb_ladybird_aclint;
   import ladybird_aclint_pkg::*;

   localparam logic [31:0] MSIP    = ACLINT_MSIP_BASE;
   localparam logic [31:0] CMP_LO  = ACLINT_MTIMECMP_BASE;
   localparam logic [31:0] CMP_HI  = ACLINT_MTIMECMP_BASE + 32'h4;
   localparam logic [31:0] TIME_LO = ACLINT_MTIME_BASE;
   localparam logic [31:0] TIME_HI = ACLINT_MTIME_BASE + 32'h4;

   typedef struct {
      bit          is_read;
      logic [31:0] data;
      logic [1:0]  resp;
   } sb_entry_t;

   logic clk = 1'b0;
   logic rst = 1'b1;
   logic timer_interrupt, software_interrupt;

   int vectors = 0;
   int miscompares = 0;
   int cyc = 0;
   int last_commit_cyc = -1;
   int ti_rise_cyc = -1, ti_fall_cyc = -1, sw_rise_cyc = -1;
   logic ti_prev = 1'b0, sw_prev = 1'b0;
   sb_entry_t exp_q[$];

   ladybird_axi_interface #(.AXI_DATA_W(32), .AXI_ADDR_W(32)) axi();

   ladybird_aclint #(.TICK_DIV(1)) dut (
      .clk                (clk),
      .rst                (rst),
      .axi                (axi),
      .timer_interrupt    (timer_interrupt),
      .software_interrupt (software_interrupt)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   always @(negedge clk) begin
      if (timer_interrupt && !ti_prev) ti_rise_cyc = cyc;
      if (!timer_interrupt && ti_prev) ti_fall_cyc = cyc;
      if (software_interrupt && !sw_prev) sw_rise_cyc = cyc;
      ti_prev = timer_interrupt;
      sw_prev = software_interrupt;
   end

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic sb_check(input bit is_read, input logic [31:0] data, input logic [1:0] resp,
                           input string tag);
      sb_entry_t e;
      check({tag, "_sb_nonempty"}, 64'(exp_q.size() != 0), 64'd1);
      if (exp_q.size() == 0) return;
      e = exp_q.pop_front();
      check({tag, "_kind"}, 64'(is_read), 64'(e.is_read));
      if (e.is_read) check({tag, "_rdata"}, data, e.data);
      check({tag, "_resp"}, resp, e.resp);
   endtask

   task automatic axi_write(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] strb,
                            input int aw_delay, input int w_delay, input int b_hold,
                            input logic [1:0] exp_resp, input string tag);
      int n;
      bit aw_done, w_done, aw_hs, w_hs, got;
      exp_q.push_back('{1'b0, 32'h0, exp_resp});
      n = 0; aw_done = 0; w_done = 0;
      @(negedge clk);
      while (!(aw_done && w_done) && n < 50) begin
         if (!aw_done && n >= aw_delay) begin axi.awaddr = addr; axi.awvalid = 1'b1; end
         if (!w_done && n >= w_delay) begin axi.wdata = data; axi.wstrb = strb; axi.wvalid = 1'b1; end
         #1;
         aw_hs = axi.awvalid && axi.awready;
         w_hs  = axi.wvalid && axi.wready;
         @(negedge clk);
         n++;
         if (aw_hs) begin aw_done = 1; axi.awvalid = 1'b0; end
         if (w_hs)  begin w_done = 1;  axi.wvalid = 1'b0; end
         if (aw_hs || w_hs) last_commit_cyc = cyc;
      end
      axi.awvalid = 1'b0; axi.wvalid = 1'b0;
      check({tag, "_aw_w_timeout"}, 64'(aw_done && w_done), 64'd1);
      check({tag, "_bvalid_next_cycle"}, axi.bvalid, 1'b1);
      for (int h = 0; h < b_hold; h++) begin
         @(negedge clk);
         check({tag, "_bvalid_hold"}, axi.bvalid, 1'b1);
         check({tag, "_bresp_hold"}, axi.bresp, exp_resp);
      end
      axi.bready = 1'b1;
      got = 0;
      for (int k = 0; k < 20 && !got; k++) begin
         #1;
         if (axi.bvalid) begin got = 1; sb_check(1'b0, 32'h0, axi.bresp, tag); end
         @(negedge clk);
      end
      axi.bready = 1'b0;
      check({tag, "_b_timeout"}, 64'(got), 64'd1);
      if (!got && exp_q.size() != 0) void'(exp_q.pop_front());
   endtask

   task automatic axi_read(input logic [31:0] addr, input logic [31:0] exp_data,
                           input logic [1:0] exp_resp, input string tag);
      bit hs, done;
      exp_q.push_back('{1'b1, exp_data, exp_resp});
      @(negedge clk);
      axi.araddr = addr; axi.arvalid = 1'b1; done = 0;
      for (int k = 0; k < 20 && !done; k++) begin
         #1;
         hs = axi.arready;
         @(negedge clk);
         if (hs) begin done = 1; axi.arvalid = 1'b0; end
      end
      axi.arvalid = 1'b0;
      check({tag, "_ar_timeout"}, 64'(done), 64'd1);
      check({tag, "_rvalid_next_cycle"}, axi.rvalid, 1'b1);
      axi.rready = 1'b1; done = 0;
      for (int k = 0; k < 20 && !done; k++) begin
         #1;
         if (axi.rvalid) begin done = 1; sb_check(1'b1, axi.rdata, axi.rresp, tag); end
         @(negedge clk);
      end
      axi.rready = 1'b0;
      check({tag, "_r_timeout"}, 64'(done), 64'd1);
      if (!done && exp_q.size() != 0) void'(exp_q.pop_front());
   endtask

   initial begin : stimulus
      int c, b_cyc, ar_cyc;
      bit r_done;

      axi.awaddr = '0; axi.awvalid = 1'b0; axi.wdata = '0; axi.wstrb = '0; axi.wvalid = 1'b0;
      axi.bready = 1'b0; axi.araddr = '0; axi.arvalid = 1'b0; axi.rready = 1'b0;

      // Reset state
      repeat (3) @(negedge clk);
      axi.awvalid = 1'b1; axi.wvalid = 1'b1; axi.arvalid = 1'b1;
      #1;
      check("rst_awready", axi.awready, 1'b0);
      check("rst_wready", axi.wready, 1'b0);
      check("rst_arready", axi.arready, 1'b0);
      axi.awvalid = 1'b0; axi.wvalid = 1'b0; axi.arvalid = 1'b0;
      @(negedge clk);
      check("rst_bvalid", axi.bvalid, 1'b0);
      check("rst_rvalid", axi.rvalid, 1'b0);
      check("rst_bresp", axi.bresp, 2'b00);
      check("rst_rresp", axi.rresp, 2'b00);
      check("rst_rdata", axi.rdata, 32'h0);
      check("rst_mtip", timer_interrupt, 1'b0);
      check("rst_msip", software_interrupt, 1'b0);
      rst = 1'b0;

      // mtimecmp reset value
      axi_read(CMP_LO, 32'hFFFF_FFFF, AXI_RESP_OKAY, "cmp_lo_reset");
      axi_read(CMP_HI, 32'hFFFF_FFFF, AXI_RESP_OKAY, "cmp_hi_reset");
      check("mtip_after_reset", timer_interrupt, 1'b0);

      // Carry from the low into the high mtime word
      axi_write(TIME_HI, 32'h0, 4'hF, 0, 0, 0, AXI_RESP_OKAY, "mtime_hi0");
      axi_write(TIME_LO, 32'hFFFF_FFFE, 4'hF, 0, 0, 0, AXI_RESP_OKAY, "mtime_lo_fffe");
      repeat (3) @(negedge clk);
      axi_read(TIME_HI, 32'h1, AXI_RESP_OKAY, "mtime_hi_carry");

      // Timer interrupt rise and fall timing
      axi_write(CMP_HI, 32'h0, 4'hF, 0, 0, 0, AXI_RESP_OKAY, "cmp_hi0");
      axi_write(CMP_LO, 32'd100, 4'hF, 0, 0, 0, AXI_RESP_OKAY, "cmp_lo100");
      axi_write(TIME_HI, 32'h0, 4'hF, 0, 0, 0, AXI_RESP_OKAY, "mtime_hi_clear");
      axi_write(TIME_LO, 32'd90, 4'hF, 0, 0, 0, AXI_RESP_OKAY, "mtime_lo90");
      c = last_commit_cyc;
      check("mtip_low_before_match", timer_interrupt, 1'b0);
      for (int k = 0; k < 40 && !timer_interrupt; k++) @(negedge clk);
      #1;
      check("mtip_rise_seen", timer_interrupt, 1'b1);
      check("mtip_rise_cycle", 64'(ti_rise_cyc), 64'(c + 11));
      axi_write(CMP_HI, 32'h1, 4'hF, 0, 0, 0, AXI_RESP_OKAY, "cmp_hi1");
      #1;
      check("mtip_fall_level", timer_interrupt, 1'b0);
      check("mtip_fall_cycle", 64'(ti_fall_cyc), 64'(last_commit_cyc + 1));

      // Partial-strobe write into mtimecmp lo
      axi_write(CMP_LO, 32'h1234_AB00, 4'b0010, 0, 0, 0, AXI_RESP_OKAY, "cmp_lo_strb");
      axi_read(CMP_LO, 32'h0000_AB64, AXI_RESP_OKAY, "cmp_lo_strb_rb");

      // W leads AW by three cycles into msip
      axi_write(MSIP, 32'h1, 4'b0001, 3, 0, 0, AXI_RESP_OKAY, "msip_split");
      #1;
      check("msip_irq_level", software_interrupt, 1'b1);
      check("msip_irq_cycle", 64'(sw_rise_cyc), 64'(last_commit_cyc + 1));
      axi_read(MSIP, 32'h1, AXI_RESP_OKAY, "msip_rb");

      // AW+W+AR together: write wins, read sees the new value
      exp_q.push_back('{1'b0, 32'h0, AXI_RESP_OKAY});
      exp_q.push_back('{1'b1, 32'h0, AXI_RESP_OKAY});
      @(negedge clk);
      axi.awaddr = MSIP; axi.wdata = 32'h0; axi.wstrb = 4'hF; axi.araddr = MSIP;
      axi.awvalid = 1'b1; axi.wvalid = 1'b1; axi.arvalid = 1'b1;
      #1;
      check("simul_ar_blocked", axi.arready, 1'b0);
      @(negedge clk);
      axi.awvalid = 1'b0; axi.wvalid = 1'b0;
      axi.bready = 1'b1; axi.rready = 1'b1;
      b_cyc = -1; ar_cyc = -1; r_done = 0;
      for (int k = 0; k < 30 && !r_done; k++) begin
         #1;
         if (axi.bvalid) begin sb_check(1'b0, 32'h0, axi.bresp, "simul_b"); b_cyc = cyc + 1; end
         if (axi.arvalid && axi.arready) ar_cyc = cyc + 1;
         if (axi.rvalid) begin sb_check(1'b1, axi.rdata, axi.rresp, "simul_r"); r_done = 1; end
         @(negedge clk);
         if (ar_cyc >= 0) axi.arvalid = 1'b0;
      end
      axi.arvalid = 1'b0; axi.bready = 1'b0; axi.rready = 1'b0;
      check("simul_r_done", 64'(r_done), 64'd1);
      check("simul_ar_after_b", 64'((b_cyc >= 0) && (ar_cyc > b_cyc)), 64'd1);

      // Unmapped address: SLVERR, stable B while stalled, nothing changes
      axi_write(MSIP + 32'h8, 32'hFFFF_FFFF, 4'hF, 0, 0, 5, AXI_RESP_SLVERR, "unmapped_wr");
      axi_read(MSIP + 32'h8, 32'h0, AXI_RESP_SLVERR, "unmapped_rd");
      axi_read(MSIP, 32'h0, AXI_RESP_OKAY, "msip_unchanged");
      axi_read(CMP_HI, 32'h1, AXI_RESP_OKAY, "cmp_hi_unchanged");
      axi_read(CMP_LO, 32'h0000_AB64, AXI_RESP_OKAY, "cmp_lo_unchanged");

      // Reset in the middle of a half-collected write
      @(negedge clk);
      axi.wdata = 32'h1; axi.wstrb = 4'h1; axi.wvalid = 1'b1;
      @(negedge clk);
      axi.wvalid = 1'b0;
      rst = 1'b1;
      repeat (2) @(negedge clk);
      rst = 1'b0;
      #1;
      check("midrst_awready", axi.awready, 1'b1);
      check("midrst_wready", axi.wready, 1'b1);
      check("midrst_bvalid", axi.bvalid, 1'b0);
      axi_read(MSIP, 32'h0, AXI_RESP_OKAY, "midrst_msip");
      axi_read(CMP_LO, 32'hFFFF_FFFF, AXI_RESP_OKAY, "midrst_cmp_lo");

      check("sb_drained", 64'(exp_q.size()), 64'd0);
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
